// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types, constants and helpers for the dmem arbiter
//
// Contents:
//   WSTRB_NONE  - strobe pattern meaning "read, no bytes written"
//   REQ_ADDR_W  - address width carried in mem_req_t (the widest ADDR_W supported)
//   mem_req_t   - one muxed memory request {addr, wdata, wstrb}
//   next_rr()   - round-robin pointer advance with wrap
package dmem_arb_pkg;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;
  localparam int         REQ_ADDR_W = 32;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
  } mem_req_t;

  // Pointer that follows port `ptr` in an n-port ring.
  function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// rtl/dmem_arbiter_rr_picker.sv - combinational round-robin winner selection
//
// Ports:
//   i_valid  in   NUM_REQ  request present per port
//   i_ptr    in   IDX_W    first port to consider this cycle
//   o_grant  out  NUM_REQ  one-hot winner, zero when nothing is valid
//   o_idx    out  IDX_W    index of the winner (0 when nothing is valid)
module rr_picker
  import dmem_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  // One extra bit so ptr + offset cannot overflow before the modulo fold.
  logic [IDX_W:0] w_cand;
  logic           w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // ptr < NUM_REQ and i < NUM_REQ, so one subtraction implements the modulo.
      w_cand = {1'b0, i_ptr} + (IDX_W+1)'(i);
      if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!w_found && i_valid[w_cand[IDX_W-1:0]]) begin
        w_found                       = 1'b1;
        o_grant[w_cand[IDX_W-1:0]]    = 1'b1;
        o_idx                         = w_cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one dmem port between requesters
//
// Ports:
//   clk        in   1               clock, all state on rising edge
//   reset      in   1               synchronous active-high reset
//   req_valid  in   NUM_REQ         request present per port
//   req_addr   in   NUM_REQ*ADDR_W  byte address per port (port i at [i*ADDR_W +: ADDR_W])
//   req_wdata  in   NUM_REQ*32      write data per port
//   req_wstrb  in   NUM_REQ*4       byte strobes per port, 0 = read
//   req_ready  out  NUM_REQ         request accepted this cycle (one-hot or zero)
//   rsp_valid  out  NUM_REQ         response valid the cycle after the grant
//   rsp_rdata  out  32              dmem contents sampled at the grant edge
//   m_addr     out  ADDR_W          to dmem address
//   m_wdata    out  32              to dmem write data
//   m_wstrb    out  4               to dmem byte strobes
//   m_rdata    in   32              from dmem, combinational read
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int PRIO0   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]     req_wdata,
  input  logic [NUM_REQ*4-1:0]      req_wstrb,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [31:0]               m_wdata,
  output logic [3:0]                m_wstrb,
  input  logic [31:0]               m_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   r_rr_ptr;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [31:0]        r_rsp_rdata;

  logic [NUM_REQ-1:0] w_pick_valid;
  logic [NUM_REQ-1:0] w_pick_grant;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  mem_req_t           w_sel;

  // With port 0 prioritised, the ring only ever arbitrates among ports 1..N-1;
  // hiding port 0 from the picker makes a pointer of 0 start the scan at port 1.
  always_comb begin
    w_pick_valid = req_valid;
    if (PRIO0 != 0) begin
      w_pick_valid[0] = 1'b0;
    end
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .i_valid (w_pick_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx)
  );

  // Nothing is granted while reset is high, which also keeps m_wstrb at zero
  // so no write can reach dmem during reset.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_any   = 1'b0;
    if (!reset) begin
      if ((PRIO0 != 0) && req_valid[0]) begin
        w_grant[0] = 1'b1;
        w_any      = 1'b1;
      end else if (|w_pick_grant) begin
        w_grant = w_pick_grant;
        w_idx   = w_pick_idx;
        w_any   = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel = '{addr: '0, wdata: '0, wstrb: WSTRB_NONE};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel.addr  = REQ_ADDR_W'(req_addr[i*ADDR_W +: ADDR_W]);
        w_sel.wdata = req_wdata[i*32 +: 32];
        w_sel.wstrb = req_wstrb[i*4 +: 4];
      end
    end
  end

  // rsp_rdata captures m_rdata at the grant edge, before any write lands,
  // so a write acknowledge returns the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_grant;
      if (w_any) begin
        r_rr_ptr    <= IDX_W'(next_rr(32'(w_idx), unsigned'(NUM_REQ)));
        r_rsp_rdata <= m_rdata;
      end
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign m_addr    = w_sel.addr[ADDR_W-1:0];
  assign m_wdata   = w_sel.wdata;
  assign m_wstrb   = w_sel.wstrb;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter, round-robin and port-0-priority builds
module tb_dmem_arbiter;

  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*32-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [N*4-1:0]  req_wstrb;

  logic [N-1:0] rdy    [2];
  logic [N-1:0] rspv   [2];
  logic [31:0]  rspd   [2];
  logic [31:0]  maddr  [2];
  logic [31:0]  mwdata [2];
  logic [3:0]   mwstrb [2];
  logic [31:0]  mrdata [2];

  // index 0: strict round-robin build, index 1: port-0-priority build
  dmem_arbiter #(.NUM_REQ(N), .ADDR_W(32), .PRIO0(0)) u_dut_rr (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(rdy[0]),
    .rsp_valid(rspv[0]), .rsp_rdata(rspd[0]), .m_addr(maddr[0]),
    .m_wdata(mwdata[0]), .m_wstrb(mwstrb[0]), .m_rdata(mrdata[0])
  );

  dmem_arbiter #(.NUM_REQ(N), .ADDR_W(32), .PRIO0(1)) u_dut_p0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(rdy[1]),
    .rsp_valid(rspv[1]), .rsp_rdata(rspd[1]), .m_addr(maddr[1]),
    .m_wdata(mwdata[1]), .m_wstrb(mwstrb[1]), .m_rdata(mrdata[1])
  );

  // dmem models: 64 words, combinational read, byte-strobed write, preload port
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;
  logic [31:0] mem [2][64];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pl_en) mem[d][pl_idx] <= pl_data;
      for (int b = 0; b < 4; b++) begin
        if (mwstrb[d][b]) mem[d][maddr[d][7:2]][b*8 +: 8] <= mwdata[d][b*8 +: 8];
      end
    end
  end

  assign mrdata[0] = mem[0][maddr[0][7:2]];
  assign mrdata[1] = mem[1][maddr[1][7:2]];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference arbitration: scan the ring starting just after the last winner;
  // the priority build takes port 0 whenever it asks and never rotates onto it.
  function automatic int pick(input int d, input logic [N-1:0] v, input int last);
    if (d == 1 && v[0]) return 0;
    for (int k = 1; k <= N; k++) begin
      int p;
      p = (last + k) % N;
      if (!(d == 1 && p == 0) && v[p]) return p;
    end
    return -1;
  endfunction

  int           last_w  [2] = '{N-1, N-1};
  logic [N-1:0] exp_rv  [2] = '{'0, '0};
  logic [31:0]  exp_rd  [2] = '{'0, '0};
  bit           rst_prev[2] = '{1'b0, 1'b0};
  logic [31:0]  rmem    [2][64];

  // Continuous reference check, sampled mid-cycle; inputs change just after posedge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int           w;
      logic [N-1:0] er;
      logic [3:0]   ews;
      logic [31:0]  ea, ewd;
      logic [5:0]   idx;
      w   = reset ? -1 : pick(d, req_valid, last_w[d]);
      er  = '0;
      ews = 4'h0;
      ea  = 32'h0;
      ewd = 32'h0;
      if (w >= 0) begin
        er[w] = 1'b1;
        ews   = req_wstrb[w*4 +: 4];
        ea    = req_addr[w*32 +: 32];
        ewd   = req_wdata[w*32 +: 32];
      end
      check($sformatf("d%0d req_ready", d), 32'(rdy[d]), 32'(er));
      check($sformatf("d%0d m_wstrb", d), 32'(mwstrb[d]), 32'(ews));
      check($sformatf("d%0d m_addr_known", d), 32'($isunknown(maddr[d])), 32'h0);
      if (!reset) check($sformatf("d%0d m_addr", d), maddr[d], ea);
      if (w >= 0) check($sformatf("d%0d m_wdata", d), mwdata[d], ewd);
      check($sformatf("d%0d rsp_valid", d), 32'(rspv[d]), 32'(exp_rv[d]));
      if (exp_rv[d] != 0 || rst_prev[d]) check($sformatf("d%0d rsp_rdata", d), rspd[d], exp_rd[d]);

      if (pl_en) rmem[d][pl_idx] = pl_data;
      if (reset) begin
        last_w[d] = N-1;
        exp_rv[d] = '0;
        exp_rd[d] = 32'h0;
      end else begin
        exp_rv[d] = er;
        if (w >= 0) begin
          idx       = ea[7:2];
          exp_rd[d] = rmem[d][idx];
          for (int b = 0; b < 4; b++) begin
            if (ews[b]) rmem[d][idx][b*8 +: 8] = ewd[b*8 +: 8];
          end
          last_w[d] = w;
        end
      end
      rst_prev[d] = reset;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int cnt0, cnt1;

  initial begin
    reset = 1'b1; req_valid = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    tick();

    // preload every word while reset is held
    for (int i = 0; i < 64; i++) begin
      pl_en   = 1'b1;
      pl_idx  = 6'(i);
      pl_data = (i == 1) ? 32'hDEADBEEF : (i == 2) ? 32'hAAAAAAAA :
                (i == 4) ? 32'h55555555 : $urandom;
      tick();
    end
    pl_en = 1'b0;

    // reset with port 0 pushing a full-word write to 0x10
    req_valid = 2'b01; req_addr[31:0] = 32'h10; req_wdata[31:0] = 32'hFFFFFFFF; req_wstrb[3:0] = 4'hF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst req_ready", 32'(rdy[0]), 32'h0);
      check("rst m_wstrb", 32'(mwstrb[0]), 32'h0);
      tick();
    end
    reset = 1'b0; req_valid = '0; req_wstrb = '0;
    @(negedge clk);
    check("rst dmem4", mem[0][4], 32'h55555555);
    check("rst rsp_valid", 32'(rspv[0]), 32'h0);
    tick();

    // single read from port 0
    req_valid = 2'b01; req_addr[31:0] = 32'h4;
    @(negedge clk);
    check("rd req_ready", 32'(rdy[0]), 32'h1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("rd rsp_valid", 32'(rspv[0]), 32'h1);
    check("rd rsp_rdata", rspd[0], 32'hDEADBEEF);
    tick();

    // port 1 partial write then read back
    req_valid = 2'b10; req_addr[63:32] = 32'h8; req_wdata[63:32] = 32'h12345678; req_wstrb[7:4] = 4'h3;
    tick();
    req_wstrb[7:4] = 4'h0;
    @(negedge clk);
    check("wr ack valid", 32'(rspv[0]), 32'h2);
    check("wr ack rdata", rspd[0], 32'hAAAAAAAA);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("wr rd valid", 32'(rspv[0]), 32'h2);
    check("wr rd rdata", rspd[0], 32'hAAAA5678);
    tick();

    // round-robin contention from rr_ptr = 0
    cnt0 = 0; cnt1 = 0;
    req_valid = 2'b11; req_addr = {32'h4, 32'h0}; req_wstrb = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rr grant%0d", k), 32'(rdy[0]), (k % 2 == 0) ? 32'h1 : 32'h2);
      cnt0 += int'(rspv[0][0]);
      cnt1 += int'(rspv[0][1]);
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    cnt0 += int'(rspv[0][0]);
    cnt1 += int'(rspv[0][1]);
    check("rr rsp count0", 32'(cnt0), 32'd3);
    check("rr rsp count1", 32'(cnt1), 32'd3);
    tick();

    // priority build: port 0 holds the port, port 1 waits until it lets go
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("p0 grant%0d", k), 32'(rdy[1]), 32'h1);
      tick();
    end
    req_valid = 2'b10;
    @(negedge clk);
    check("p0 port1 granted", 32'(rdy[1]), 32'h2);
    tick();
    req_valid = '0;
    tick();

    // reset the cycle after a granted read from 0x0
    req_valid = 2'b01; req_addr[31:0] = 32'h0;
    @(negedge clk);
    check("mid grant", 32'(rdy[0]), 32'h1);
    tick();
    reset = 1'b1; req_valid = '0;
    tick();
    reset = 1'b0; req_valid = 2'b11;
    @(negedge clk);
    check("mid rsp dropped", 32'(rspv[0]), 32'h0);
    check("mid next grant", 32'(rdy[0]), 32'h1);
    tick();
    req_valid = '0;
    tick();

    // random traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      reset     = ($urandom_range(0, 49) == 0);
      req_valid = N'($urandom);
      for (int p = 0; p < N; p++) begin
        req_addr[p*32 +: 32]  = $urandom_range(0, 255);
        req_wdata[p*32 +: 32] = $urandom;
        req_wstrb[p*4 +: 4]   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      end
      tick();
    end
    reset = 1'b0; req_valid = '0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
